// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared ALU.
// One transaction is outstanding at a time. NOP and unknown op codes are
// answered locally, and a timeout bounds the time spent waiting on the ALU.
module alu_arbiter #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [7:0]        req_op0,
    input  logic [7:0]        req_op1,
    input  logic [DATA_W-1:0] req_a0,
    input  logic [DATA_W-1:0] req_b0,
    input  logic [DATA_W-1:0] req_a1,
    input  logic [DATA_W-1:0] req_b1,
    output logic [1:0]        gnt,
    output logic              alu_valid,
    output logic [7:0]        alu_op,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic              alu_ready,
    input  logic              alu_done,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [7:0]        alu_status,
    output logic [1:0]        rsp_valid,
    output logic [DATA_W-1:0] rsp_result,
    output logic [7:0]        rsp_status
);

    localparam logic [7:0] OP_NOP    = 8'h00;
    localparam logic [7:0] OP_AND    = 8'h01;
    localparam logic [7:0] OP_OR     = 8'h02;
    localparam logic [7:0] OP_XOR    = 8'h03;
    localparam logic [7:0] OP_ADD    = 8'h10;
    localparam logic [7:0] OP_SUB    = 8'h20;
    localparam logic [7:0] OP_RST_ST = 8'hFF;

    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_TIMEOUT = 8'h01;
    localparam logic [7:0] ST_INVALID = 8'h80;

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 2);
    // The counter is compared one step early so that it "reaches"
    // TIMEOUT_CYCLES on the same edge that leaves ISSUE/WAIT.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state;
    logic              last;      // requester served most recently
    logic              sel;       // requester owning the current transaction
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] res_q;
    logic [7:0]        st_q;

    logic              pick;
    logic [7:0]        op_sel;
    logic [DATA_W-1:0] a_sel;
    logic [DATA_W-1:0] b_sel;
    logic              op_ok;
    logic              timed_out;

    // Round-robin choice, selected command and op-code classification.
    always_comb begin
        pick = 1'b0;
        if (req[0] && req[1]) begin
            pick = ~last;
        end else if (req[1]) begin
            pick = 1'b1;
        end
        op_sel = pick ? req_op1 : req_op0;
        a_sel  = pick ? req_a1  : req_a0;
        b_sel  = pick ? req_b1  : req_b0;
        unique case (op_sel)
            OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_RST_ST: op_ok = 1'b1;
            default:                                          op_ok = 1'b0;
        endcase
        timed_out = (cnt >= CNT_LAST);
    end

    // Transaction FSM with registered grant, ALU command and response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last       <= 1'b1;
            sel        <= 1'b0;
            cnt        <= '0;
            res_q      <= '0;
            st_q       <= '0;
            gnt        <= '0;
            alu_valid  <= 1'b0;
            alu_op     <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_status <= '0;
        end else begin
            gnt       <= '0;
            rsp_valid <= '0;
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        gnt    <= pick ? 2'b10 : 2'b01;
                        last   <= pick;
                        sel    <= pick;
                        alu_op <= op_sel;
                        alu_a  <= a_sel;
                        alu_b  <= b_sel;
                        cnt    <= '0;
                        if (op_ok) begin
                            state     <= ISSUE;
                            alu_valid <= 1'b1;
                        end else begin
                            state <= RESP;
                            res_q <= '0;
                            st_q  <= (op_sel == OP_NOP) ? ST_OK : ST_INVALID;
                        end
                    end
                end
                ISSUE: begin
                    cnt <= cnt + 1'b1;
                    if (timed_out) begin
                        state     <= RESP;
                        alu_valid <= 1'b0;
                        res_q     <= '0;
                        st_q      <= ST_TIMEOUT;
                    end else if (alu_ready) begin
                        state     <= WAIT;
                        alu_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (timed_out) begin
                        state <= RESP;
                        res_q <= '0;
                        st_q  <= ST_TIMEOUT;
                    end else if (alu_done) begin
                        state <= RESP;
                        res_q <= alu_result;
                        st_q  <= alu_status;
                    end
                end
                RESP: begin
                    rsp_valid  <= sel ? 2'b10 : 2'b01;
                    rsp_result <= res_q;
                    rsp_status <= st_q;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: tasks push expected responses when they
// drive requests; a negedge monitor pops and compares every rsp_valid pulse.
module tb_alu_arbiter;

    localparam int DW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    req;
    logic [7:0]    req_op0, req_op1;
    logic [DW-1:0] req_a0, req_b0, req_a1, req_b1;
    logic [1:0]    gnt;
    logic          alu_valid;
    logic [7:0]    alu_op;
    logic [DW-1:0] alu_a, alu_b;
    logic          alu_ready, alu_done;
    logic [DW-1:0] alu_result;
    logic [7:0]    alu_status;
    logic [1:0]    rsp_valid;
    logic [DW-1:0] rsp_result;
    logic [7:0]    rsp_status;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]  v;
        logic [31:0] r;
        logic [7:0]  s;
    } exp_t;
    exp_t sb[$];

    alu_arbiter #(.DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .req(req),
        .req_op0(req_op0), .req_op1(req_op1),
        .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
        .gnt(gnt), .alu_valid(alu_valid), .alu_op(alu_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ready(alu_ready),
        .alu_done(alu_done), .alu_result(alu_result), .alu_status(alu_status),
        .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_status(rsp_status)
    );

    always #5 clk = ~clk;

    // Response monitor: every pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rsp_valid !== 2'b00) begin
            exp_t e;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: valid=%b result=%0h status=%0h, required no response",
                         rsp_valid, rsp_result, rsp_status);
            end else begin
                e = sb.pop_front();
                if (rsp_valid !== e.v || rsp_result !== e.r || rsp_status !== e.s) begin
                    errors++;
                    $display("FAIL rsp: valid=%b result=%0h status=%0h, required valid=%b result=%0h status=%0h",
                             rsp_valid, rsp_result, rsp_status, e.v, e.r, e.s);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_gnt(output logic [1:0] g, output bit ok);
        ok = 1'b0;
        g  = 2'b00;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (gnt !== 2'b00) begin
                g  = gnt;
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Called on the negedge where gnt is seen; plays the ALU side.
    task automatic alu_serve(input int rdy_wait, input int done_wait,
                             input logic [31:0] res, input logic [7:0] st,
                             output bit ok);
        ok = (alu_valid === 1'b1);
        if (ok) begin
            repeat (rdy_wait) @(negedge clk);
            alu_ready = 1'b1;
            @(negedge clk);
            alu_ready = 1'b0;
            repeat (done_wait) @(negedge clk);
            alu_result = res;
            alu_status = st;
            alu_done   = 1'b1;
            @(negedge clk);
            alu_done   = 1'b0;
        end
    endtask

    task automatic wait_drain(output bit ok);
        for (int n = 0; n < 40 && sb.size() != 0; n++) @(negedge clk);
        @(negedge clk);
        ok = (sb.size() == 0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({gnt, alu_valid, rsp_valid} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctrl: gnt=%b alu_valid=%b rsp_valid=%b, required all 0", gnt, alu_valid, rsp_valid);
        end
        checks++;
        if ({alu_op, alu_a, alu_b, rsp_result, rsp_status} !== '0) begin
            errors++;
            $display("FAIL reset_data: op=%0h a=%0h b=%0h result=%0h status=%0h, required all 0",
                     alu_op, alu_a, alu_b, rsp_result, rsp_status);
        end
        rst = 1'b0;
    endtask

    task automatic test_add();
        logic [1:0] g;
        bit ok;
        req_op0 = 8'h10; req_a0 = 5; req_b0 = 7; req = 2'b01;
        sb.push_back('{v: 2'b01, r: 32'd12, s: 8'h00});
        wait_gnt(g, ok);
        req = 2'b00;
        checks++;
        if (!ok || g !== 2'b01) begin
            errors++;
            $display("FAIL add_gnt: gnt=%b, required 01", g);
        end
        checks++;
        if (alu_valid !== 1'b1 || alu_op !== 8'h10 || alu_a !== 5 || alu_b !== 7) begin
            errors++;
            $display("FAIL add_cmd: valid=%b op=%0h a=%0h b=%0h, required 1 10 5 7", alu_valid, alu_op, alu_a, alu_b);
        end
        alu_serve(0, 1, 32'd12, 8'h00, ok);
        checks++;
        if (alu_valid !== 1'b0) begin
            errors++;
            $display("FAIL add_valid_drop: alu_valid=%b, required 0", alu_valid);
        end
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL add_drain: %0d responses missing, required 0", sb.size());
        end
    endtask

    task automatic test_round_robin();
        logic [1:0] g;
        bit ok;
        int who;
        do_reset();
        req_op0 = 8'h10; req_a0 = 1;  req_b0 = 2;
        req_op1 = 8'h20; req_a1 = 10; req_b1 = 3;
        req = 2'b11;
        for (int i = 0; i < 3; i++) begin
            who = i % 2;
            wait_gnt(g, ok);
            if (i == 2) req = 2'b00;
            checks++;
            if (!ok || g !== (who == 1 ? 2'b10 : 2'b01)) begin
                errors++;
                $display("FAIL rr_order%0d: gnt=%b, required requester %0d", i, g, who);
            end
            checks++;
            if (alu_a !== (who == 1 ? 32'd10 : 32'd1) || alu_op !== (who == 1 ? 8'h20 : 8'h10)) begin
                errors++;
                $display("FAIL rr_operands%0d: op=%0h a=%0h, required requester %0d operands", i, alu_op, alu_a, who);
            end
            sb.push_back('{v: (who == 1 ? 2'b10 : 2'b01), r: (who == 1 ? 32'd7 : 32'd3), s: 8'h00});
            alu_serve(0, 0, (who == 1 ? 32'd7 : 32'd3), 8'h00, ok);
        end
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rr_drain: %0d responses missing, required 0", sb.size());
        end
    endtask

    task automatic test_nop_invalid();
        logic [1:0] g;
        bit ok;
        req_op1 = 8'hB3; req_a1 = 32'h1234; req_b1 = 32'h5678; req = 2'b10;
        sb.push_back('{v: 2'b10, r: 32'd0, s: 8'h80});
        wait_gnt(g, ok);
        req = 2'b00;
        checks++;
        if (!ok || g !== 2'b10 || alu_valid !== 1'b0) begin
            errors++;
            $display("FAIL inv_gnt: gnt=%b alu_valid=%b, required 10 and 0", g, alu_valid);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 2'b10 || alu_valid !== 1'b0) begin
            errors++;
            $display("FAIL inv_latency: rsp_valid=%b alu_valid=%b, required 10 and 0", rsp_valid, alu_valid);
        end
        req_op0 = 8'h00; req_a0 = 32'h99; req = 2'b01;
        sb.push_back('{v: 2'b01, r: 32'd0, s: 8'h00});
        wait_gnt(g, ok);
        req = 2'b00;
        checks++;
        if (!ok || g !== 2'b01 || alu_valid !== 1'b0) begin
            errors++;
            $display("FAIL nop_gnt: gnt=%b alu_valid=%b, required 01 and 0", g, alu_valid);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 2'b01 || alu_valid !== 1'b0) begin
            errors++;
            $display("FAIL nop_latency: rsp_valid=%b alu_valid=%b, required 01 and 0", rsp_valid, alu_valid);
        end
    endtask

    task automatic test_timeout();
        logic [1:0] g;
        bit ok;
        int n;
        req_op0 = 8'h10; req_a0 = 3; req_b0 = 4; req = 2'b01;
        sb.push_back('{v: 2'b01, r: 32'd0, s: 8'h01});
        wait_gnt(g, ok);
        req = 2'b00;
        n = 0;
        while (alu_valid === 1'b1 && n < 30) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != TO) begin
            errors++;
            $display("FAIL timeout_valid_cycles: alu_valid high %0d cycles, required %0d", n, TO);
        end
        @(negedge clk);
        checks++;
        if (rsp_valid !== 2'b01) begin
            errors++;
            $display("FAIL timeout_rsp: rsp_valid=%b, required 01", rsp_valid);
        end
    endtask

    task automatic test_done_boundary();
        logic [1:0] g;
        bit ok;
        // Done one cycle before the limit is still accepted.
        req_op0 = 8'h03; req_a0 = 32'hF; req_b0 = 32'h3; req = 2'b01;
        sb.push_back('{v: 2'b01, r: 32'hDEAD, s: 8'h04});
        wait_gnt(g, ok);
        req = 2'b00;
        alu_serve(0, TO - 3, 32'hDEAD, 8'h04, ok);
        // Done on the limit cycle loses to the timeout.
        req_op1 = 8'h02; req_a1 = 32'h1; req_b1 = 32'h2; req = 2'b10;
        wait_gnt(g, ok);
        req = 2'b00;
        sb.push_back('{v: 2'b10, r: 32'd0, s: 8'h01});
        alu_serve(0, TO - 2, 32'hBEEF, 8'h00, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL boundary_serve: alu_valid=%b at grant, required 1", alu_valid);
        end
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL boundary_drain: %0d responses missing, required 0", sb.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] g;
        bit ok;
        req_op0 = 8'h10; req_a0 = 32'h20; req_b0 = 32'h22; req = 2'b01;
        wait_gnt(g, ok);
        req = 2'b00;
        alu_ready = 1'b1;
        @(negedge clk);
        alu_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        alu_result = 32'h55; alu_status = 8'h00; alu_done = 1'b1;
        @(negedge clk);
        alu_done = 1'b0;
        checks++;
        if ({gnt, alu_valid, rsp_valid, alu_op, alu_a, alu_b, rsp_result, rsp_status} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: gnt=%b valid=%b rsp=%b op=%0h a=%0h b=%0h result=%0h status=%0h, required all 0",
                     gnt, alu_valid, rsp_valid, alu_op, alu_a, alu_b, rsp_result, rsp_status);
        end
        repeat (3) @(negedge clk);
        req_op0 = 8'h01; req_a0 = 32'hF0; req_b0 = 32'h3C;
        req_op1 = 8'h02; req_a1 = 32'h11; req_b1 = 32'h22;
        req = 2'b11;
        wait_gnt(g, ok);
        req = 2'b00;
        checks++;
        if (!ok || g !== 2'b01) begin
            errors++;
            $display("FAIL midreset_rr: gnt=%b, required 01", g);
        end
        sb.push_back('{v: 2'b01, r: 32'h30, s: 8'h00});
        alu_serve(0, 0, 32'h30, 8'h00, ok);
        wait_drain(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL midreset_drain: %0d responses missing, required 0", sb.size());
        end
    endtask

    initial begin
        rst = 1'b1; req = 2'b00;
        req_op0 = '0; req_op1 = '0;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
        alu_ready = 1'b0; alu_done = 1'b0; alu_result = '0; alu_status = '0;
        test_reset();
        test_add();
        test_round_robin();
        test_nop_invalid();
        test_timeout();
        test_done_boundary();
        test_reset_mid();
        repeat (3) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL final_drain: %0d responses outstanding, required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
